// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Brief    : Buffers A/B row loads, runs the clear/feed/drain sequence on the
//            systolic array and replays captured result rows on a ready/valid port.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_sequencer #(
  parameter  int DATAWIDTH = 16,
  parameter  int N_SIZE    = 5,
  parameter  int TIMEOUT   = 64,
  localparam int IW        = $clog2(N_SIZE)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                err_incomplete,
  output logic                                err_timeout,
  input  logic                                ld_valid,
  output logic                                ld_ready,
  input  logic                                ld_sel,
  input  logic [IW-1:0]                       ld_idx,
  input  logic [N_SIZE-1:0][DATAWIDTH-1:0]    ld_row,
  output logic                                arr_rst_n,
  output logic                                arr_valid_in,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]    arr_a,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]    arr_b,
  input  logic                                arr_valid_out,
  input  logic [N_SIZE-1:0][2*DATAWIDTH-1:0]  arr_row,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [IW-1:0]                       res_idx,
  output logic [N_SIZE-1:0][2*DATAWIDTH-1:0]  res_row
);

  localparam int            CW         = IW + 1;
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam int            RW         = 2 * DATAWIDTH;
  localparam logic [CW-1:0] C_LAST     = CW'(N_SIZE - 1);
  localparam logic [CW-1:0] C_FULL     = CW'(N_SIZE);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] C_TMO_MAX  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state, state_n;

  // Operand buffers are indexed [row][col] and deliberately carry no reset.
  logic [DATAWIDTH-1:0]      a_buf  [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0]      b_buf  [N_SIZE][N_SIZE];
  logic [N_SIZE-1:0][RW-1:0] result [N_SIZE];

  logic [N_SIZE-1:0] mask_a, mask_b;
  logic [CW-1:0]     t_cnt, cap_cnt, r_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [IW-1:0]     t_idx, cap_idx, r_idx;

  logic load_we, mask_full, cap_now, cap_done, tmo_hit;
  logic go_clr, incomplete, timeout, finish;

  assign t_idx     = t_cnt[IW-1:0];
  assign cap_idx   = cap_cnt[IW-1:0];
  assign r_idx     = r_cnt[IW-1:0];
  assign load_we   = (state == S_IDLE) && ld_valid && ({1'b0, ld_idx} < C_FULL);
  assign mask_full = (&mask_a) && (&mask_b);
  assign cap_now   = arr_valid_out && ((state == S_FEED) || (state == S_DRAIN)) && (cap_cnt < C_FULL);
  assign cap_done  = (cap_cnt == C_FULL) || (cap_now && (cap_cnt == C_LAST));
  assign tmo_hit   = (tmo_cnt == C_TMO_LAST);

  always_comb begin
    state_n    = state;
    go_clr     = 1'b0;
    incomplete = 1'b0;
    timeout    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mask_full) begin
            state_n = S_CLR;
            go_clr  = 1'b1;
          end else begin
            incomplete = 1'b1;
          end
        end
      end
      S_CLR:  state_n = S_FEED;
      S_FEED: begin
        if (t_cnt == C_LAST) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        // A completed capture wins over a coincident timeout.
        if (cap_done) begin
          state_n = S_OUT;
        end else if (tmo_hit) begin
          state_n = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready && (r_cnt == C_LAST)) begin
          state_n = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      for (int c = 0; c < N_SIZE; c++) begin
        if (ld_sel) b_buf[ld_idx][c] <= ld_row[c];
        else        a_buf[ld_idx][c] <= ld_row[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      mask_a         <= '0;
      mask_b         <= '0;
      t_cnt          <= '0;
      cap_cnt        <= '0;
      r_cnt          <= '0;
      tmo_cnt        <= '0;
      done           <= 1'b0;
      err_incomplete <= 1'b0;
      err_timeout    <= 1'b0;
      arr_rst_n      <= 1'b0;
      for (int i = 0; i < N_SIZE; i++) result[i] <= '0;
    end else begin
      state          <= state_n;
      done           <= finish;
      err_incomplete <= incomplete;
      err_timeout    <= timeout;
      arr_rst_n      <= (state_n != S_CLR);

      if (go_clr) begin
        mask_a <= '0;
        mask_b <= '0;
      end else if (load_we) begin
        if (ld_sel) mask_b[ld_idx] <= 1'b1;
        else        mask_a[ld_idx] <= 1'b1;
      end

      case (state)
        S_CLR: begin
          t_cnt   <= '0;
          cap_cnt <= '0;
        end
        S_FEED: begin
          t_cnt   <= t_cnt + 1'b1;
          tmo_cnt <= '0;
        end
        S_DRAIN: begin
          if (tmo_cnt != C_TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
          r_cnt <= '0;
        end
        S_OUT: begin
          if (res_ready) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase

      if (cap_now) begin
        result[cap_idx] <= arr_row;
        cap_cnt         <= cap_cnt + 1'b1;
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign ld_ready     = (state == S_IDLE);
  assign arr_valid_in = (state == S_FEED);
  assign res_valid    = (state == S_OUT);
  assign res_idx      = res_valid ? r_idx : '0;
  assign res_row      = res_valid ? result[r_idx] : '0;

  // Column t of A and row t of B, so lane q sees A[q][t] and B[t][q].
  generate
    for (genvar q = 0; q < N_SIZE; q++) begin : g_feed
      assign arr_a[q] = arr_valid_in ? a_buf[q][t_idx] : '0;
      assign arr_b[q] = arr_valid_in ? b_buf[t_idx][q] : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_sequencer
// Brief    : Behavioural outer-product array model plus a result-row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_sequencer;

  localparam int DW    = 16;
  localparam int N     = 3;
  localparam int TMO   = 20;
  localparam int IW    = $clog2(N);
  localparam int RW    = 2 * DW;
  localparam int DELAY = 3;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, ld_valid = 1'b0, ld_sel = 1'b0, res_ready = 1'b0;
  logic [IW-1:0] ld_idx = '0;
  logic [N-1:0][DW-1:0] ld_row = '0;
  logic busy, done, err_incomplete, err_timeout, ld_ready, arr_rst_n, arr_valid_in, res_valid;
  logic [N-1:0][DW-1:0] arr_a, arr_b;
  logic arr_valid_out;
  logic [N-1:0][RW-1:0] arr_row, res_row;
  logic [IW-1:0] res_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int ma [N][N];
  int mb [N][N];
  logic [N-1:0][RW-1:0] exp_q [$];
  bit model_en = 1'b1;

  systolic_sequencer #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_incomplete(err_incomplete), .err_timeout(err_timeout),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_row(ld_row),
    .arr_rst_n(arr_rst_n), .arr_valid_in(arr_valid_in), .arr_a(arr_a), .arr_b(arr_b),
    .arr_valid_out(arr_valid_out), .arr_row(arr_row),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_row(res_row)
  );

  always #5 clk = ~clk;

  // Array model: accumulates outer products of the feed lanes, emits rows DELAY cycles later.
  logic signed [RW-1:0] acc [N][N];
  int m_feeds, m_wait, m_emit;
  always @(posedge clk) begin
    arr_valid_out <= 1'b0;
    if (!arr_rst_n) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] <= '0;
      m_feeds <= 0;
      m_wait  <= -1;
      m_emit  <= 0;
    end else if (arr_valid_in) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= acc[i][j] + RW'($signed(arr_a[i])) * RW'($signed(arr_b[j]));
      m_feeds <= m_feeds + 1;
      if (m_feeds == N - 1) m_wait <= DELAY;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (m_wait == 0 && model_en) begin
      arr_valid_out <= 1'b1;
      for (int j = 0; j < N; j++) arr_row[j] <= acc[m_emit][j];
      m_emit <= m_emit + 1;
      if (m_emit == N - 1) m_wait <= -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input bit sel, input int idx);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_idx   = IW'(idx);
    for (int c = 0; c < N; c++) begin
      if (idx < N) ld_row[c] = DW'(sel ? mb[idx][c] : ma[idx][c]);
      else         ld_row[c] = 16'h7777;
    end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      load_row(1'b0, i);
      load_row(1'b1, i);
    end
  endtask

  task automatic push_expected();
    logic [N-1:0][RW-1:0] row;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        row[j] = RW'(s);
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pops and compares result rows; pat bit p gives res_ready for the p-th cycle of OUT.
  task automatic collect(input logic [4:0] pat, input string nm);
    int budget = 100;
    int got    = 0;
    int pi     = 0;
    int dones  = 0;
    while (!res_valid && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (!res_valid) begin
      $display("FAIL %s_wait: res_valid=%0b, required 1 within budget", nm, res_valid);
      exp_q.delete();
      return;
    end
    n_pass++;
    while (got < N && budget > 0) begin
      res_ready = pat[pi % 5];
      pi++;
      n_checks++;
      if (!res_valid || res_idx !== IW'(got) || res_row !== exp_q[0])
        $display("FAIL %s_row: valid=%0b idx=%0d row=%h, required idx=%0d row=%h",
                 nm, res_valid, res_idx, res_row, got, exp_q[0]);
      else n_pass++;
      if (done) dones++;
      if (res_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      tick();
      budget--;
    end
    res_ready = 1'b0;
    if (done) dones++;
    n_checks++;
    if (done !== 1'b1 || dones != 1)
      $display("FAIL %s_done: done=%0b pulses=%0d, required done=1 pulses=1", nm, done, dones);
    else n_pass++;
    tick();
    n_checks++;
    if ({done, busy, ld_ready} !== 3'b001)
      $display("FAIL %s_idle: done/busy/ld_ready=%b, required 001", nm, {done, busy, ld_ready});
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, err_incomplete, err_timeout, ld_ready, arr_rst_n, arr_valid_in, res_valid} !== 8'b0000_1000)
      $display("FAIL reset_flags: got %b, required 00001000",
               {busy, done, err_incomplete, err_timeout, ld_ready, arr_rst_n, arr_valid_in, res_valid});
    else n_pass++;
    n_checks++;
    if (res_row !== '0 || res_idx !== '0 || arr_a !== '0 || arr_b !== '0)
      $display("FAIL reset_data: res_row=%h res_idx=%0d arr_a=%h arr_b=%h, required all 0",
               res_row, res_idx, arr_a, arr_b);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({arr_rst_n, ld_ready} !== 2'b11)
      $display("FAIL reset_release: arr_rst_n/ld_ready=%b, required 11", {arr_rst_n, ld_ready});
    else n_pass++;
  endtask

  task automatic test_identity();
    logic [N-1:0][DW-1:0] ea, eb;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * N + j + 1;
      end
    load_all();
    push_expected();
    pulse_start();
    n_checks++;
    if ({arr_rst_n, busy, arr_valid_in} !== 3'b010)
      $display("FAIL ident_clr: arr_rst_n/busy/arr_valid_in=%b, required 010", {arr_rst_n, busy, arr_valid_in});
    else n_pass++;
    tick();
    for (int t = 0; t < N; t++) begin
      for (int q = 0; q < N; q++) begin
        ea[q] = DW'(ma[q][t]);
        eb[q] = DW'(mb[t][q]);
      end
      n_checks++;
      if ({arr_valid_in, arr_rst_n} !== 2'b11 || arr_a !== ea || arr_b !== eb)
        $display("FAIL ident_feed_t%0d: valid=%0b rst_n=%0b a=%h b=%h, required valid=1 rst_n=1 a=%h b=%h",
                 t, arr_valid_in, arr_rst_n, arr_a, arr_b, ea, eb);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({arr_valid_in, busy} !== 2'b01)
      $display("FAIL ident_drain: arr_valid_in/busy=%b, required 01", {arr_valid_in, busy});
    else n_pass++;
    collect(5'b11111, "ident");
  endtask

  task automatic test_signed();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -2;
        mb[i][j] = 3;
      end
    load_all();
    push_expected();
    pulse_start();
    collect(5'b11111, "signed");
  endtask

  task automatic test_incomplete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i + 2 * j - 3;
        mb[i][j] = 5 - i * j;
      end
    for (int i = 0; i < N; i++) load_row(1'b0, i);
    load_row(1'b1, 0);
    load_row(1'b1, 1);
    load_row(1'b1, 3);
    pulse_start();
    n_checks++;
    if ({err_incomplete, busy} !== 2'b10)
      $display("FAIL incomplete_pulse: err_incomplete/busy=%b, required 10", {err_incomplete, busy});
    else n_pass++;
    tick();
    n_checks++;
    if ({err_incomplete, busy} !== 2'b00)
      $display("FAIL incomplete_clear: err_incomplete/busy=%b, required 00", {err_incomplete, busy});
    else n_pass++;
    // Row write alongside start: the mask check must still see the old mask.
    ld_valid = 1'b1;
    ld_sel   = 1'b1;
    ld_idx   = IW'(2);
    for (int c = 0; c < N; c++) ld_row[c] = DW'(mb[2][c]);
    start = 1'b1;
    tick();
    ld_valid = 1'b0;
    start    = 1'b0;
    n_checks++;
    if ({err_incomplete, busy} !== 2'b10)
      $display("FAIL incomplete_samecycle: err_incomplete/busy=%b, required 10", {err_incomplete, busy});
    else n_pass++;
    push_expected();
    pulse_start();
    collect(5'b11111, "incomplete_retry");
  endtask

  task automatic test_timeout();
    int k = 0;
    model_en = 1'b0;
    load_all();
    pulse_start();
    for (int i = 0; i < N + 1; i++) tick();
    while (!err_timeout && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != TMO)
      $display("FAIL timeout_cycles: err_timeout after %0d cycles, required %0d", k, TMO);
    else n_pass++;
    n_checks++;
    if ({err_timeout, done, busy, ld_ready} !== 4'b1001)
      $display("FAIL timeout_state: err_timeout/done/busy/ld_ready=%b, required 1001",
               {err_timeout, done, busy, ld_ready});
    else n_pass++;
    tick();
    n_checks++;
    if (err_timeout !== 1'b0)
      $display("FAIL timeout_pulse: err_timeout=%0b, required 0", err_timeout);
    else n_pass++;
    model_en = 1'b1;
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(200)) - 100;
        mb[i][j] = int'($urandom_range(200)) - 100;
      end
    load_all();
    push_expected();
    pulse_start();
    collect(5'b11001, "stall");
  endtask

  task automatic test_reset_mid();
    load_all();
    pulse_start();
    tick();
    tick();
    n_checks++;
    if (arr_valid_in !== 1'b1 || arr_a[0] !== DW'(ma[0][1]))
      $display("FAIL midrst_feed: arr_valid_in=%0b arr_a[0]=%h, required 1 and %h",
               arr_valid_in, arr_a[0], DW'(ma[0][1]));
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, err_incomplete, err_timeout, ld_ready, arr_rst_n, arr_valid_in, res_valid} !== 8'b0000_1000
        || arr_a !== '0 || res_row !== '0)
      $display("FAIL midrst_flags: flags=%b arr_a=%h res_row=%h, required 00001000 and zero data",
               {busy, done, err_incomplete, err_timeout, ld_ready, arr_rst_n, arr_valid_in, res_valid},
               arr_a, res_row);
    else n_pass++;
    rst = 1'b0;
    tick();
    pulse_start();
    n_checks++;
    if ({err_incomplete, busy} !== 2'b10)
      $display("FAIL midrst_mask: err_incomplete/busy=%b, required 10", {err_incomplete, busy});
    else n_pass++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_incomplete();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
